// File: rtl/spike_encoder_if.sv
// Spike-encoder bus: the value-vector handshake, the flush request, and the
// race-logic spike/timing outputs. The producer side (input buffer / bench)
// uses master; the encoder uses slave.
interface spike_encoder_if #(
  parameter int NUM_SPIKES = 4,
  parameter int VAL_W      = 4,
  parameter int CNT_W      = 3
);
  logic                        in_valid;
  logic                        in_ready;
  logic [NUM_SPIKES*VAL_W-1:0] in_vals;
  logic                        flush;
  logic [NUM_SPIKES-1:0]       should_spike_out_l;
  logic                        gamma_start;
  logic                        gamma_done;
  logic [CNT_W-1:0]            gamma_cnt;

  modport master (
    output in_valid,
    output in_vals,
    output flush,
    input  in_ready,
    input  should_spike_out_l,
    input  gamma_start,
    input  gamma_done,
    input  gamma_cnt
  );

  modport slave (
    input  in_valid,
    input  in_vals,
    input  flush,
    output in_ready,
    output should_spike_out_l,
    output gamma_start,
    output gamma_done,
    output gamma_cnt
  );
endinterface

// File: rtl/spike_encoder.sv
// Race-logic temporal encoder: each latched value becomes an active-low spike
// whose onset time within one gamma window equals the value.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a value vector; in_ready high, all lines high
// RUN   | gamma window in progress; cnt = time step k, lines fall at k >= value
// REST  | one all-high cycle so downstream race state can clear
module spike_encoder #(
  parameter int NUM_SPIKES = 4,
  parameter int VAL_W      = 4,
  parameter int GAMMA_LEN  = 8
) (
  input  logic          clk,
  input  logic          rst_l,
  spike_encoder_if.slave bus
);

  localparam int CNT_W = $clog2(GAMMA_LEN);
  localparam int CMP_W = (VAL_W > CNT_W) ? VAL_W : CNT_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(GAMMA_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_REST = 2'd2
  } state_e;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [NUM_SPIKES*VAL_W-1:0] vals_q, vals_d;

  logic [NUM_SPIKES-1:0]       spike_l_q, spike_l_d;
  logic                        in_ready_q, in_ready_d;
  logic                        gamma_start_q, gamma_start_d;
  logic                        gamma_done_q, gamma_done_d;
  logic [CNT_W-1:0]            gamma_cnt_q, gamma_cnt_d;
  logic                        run_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    vals_d  = vals_q;
    case (state_q)
      ST_IDLE: begin
        // An accept outranks a simultaneous flush here.
        if (bus.in_valid) begin
          vals_d  = bus.in_vals;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.flush) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_REST;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_REST: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Outputs are computed from the next state so they can be registered
  // without adding a cycle of latency to the first spike.
  always_comb begin
    run_d         = (state_d == ST_RUN);
    in_ready_d    = (state_d == ST_IDLE);
    gamma_start_d = run_d && (cnt_d == '0);
    gamma_done_d  = run_d && (cnt_d == LAST);
    gamma_cnt_d   = run_d ? cnt_d : '0;
    spike_l_d     = '1;
    for (int i = 0; i < NUM_SPIKES; i++) begin
      spike_l_d[i] = ~(run_d &&
                       (CMP_W'(vals_d[i*VAL_W +: VAL_W]) <= CMP_W'(cnt_d)));
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      vals_q        <= '0;
      spike_l_q     <= '1;
      in_ready_q    <= 1'b1;
      gamma_start_q <= 1'b0;
      gamma_done_q  <= 1'b0;
      gamma_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      vals_q        <= vals_d;
      spike_l_q     <= spike_l_d;
      in_ready_q    <= in_ready_d;
      gamma_start_q <= gamma_start_d;
      gamma_done_q  <= gamma_done_d;
      gamma_cnt_q   <= gamma_cnt_d;
    end
  end

  assign bus.should_spike_out_l = spike_l_q;
  assign bus.in_ready           = in_ready_q;
  assign bus.gamma_start        = gamma_start_q;
  assign bus.gamma_done         = gamma_done_q;
  assign bus.gamma_cnt          = gamma_cnt_q;

  // Once a line has fallen within a window it must stay low until REST.
  property p_monotonic;
    @(posedge clk) disable iff (!rst_l)
      (state_q == ST_RUN && cnt_q != '0) |-> ((spike_l_q & ~$past(spike_l_q)) == '0);
  endproperty
  a_monotonic: assert property (p_monotonic);

  property p_idle_quiet;
    @(posedge clk) disable iff (!rst_l)
      in_ready_q |-> (&spike_l_q && !gamma_start_q && !gamma_done_q);
  endproperty
  a_idle_quiet: assert property (p_idle_quiet);

endmodule

// File: tb/tb_spike_encoder.sv
// Bench for spike_encoder: directed and randomized gamma windows checked
// against a timing model built directly from the value -> spike-time rule.
module tb_spike_encoder;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int L  = 8;
  localparam int CW = $clog2(L);

  typedef logic [N*W-1:0] vec_t;

  logic clk   = 1'b0;
  logic rst_l = 1'b0;
  always #5 clk = ~clk;

  spike_encoder_if #(.NUM_SPIKES(N), .VAL_W(W), .CNT_W(CW)) bus ();

  spike_encoder #(.NUM_SPIKES(N), .VAL_W(W), .GAMMA_LEN(L)) dut (
    .clk   (clk),
    .rst_l (rst_l),
    .bus   (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Lane i is low at time step k iff its value has been reached.
  function automatic logic [N-1:0] model_spikes(input vec_t v, input int k);
    logic [N-1:0] m;
    m = '1;
    for (int i = 0; i < N; i++) begin
      int val;
      val = int'(v[i*W +: W]);
      if (val <= k) m[i] = 1'b0;
    end
    return m;
  endfunction

  function automatic vec_t pack4(input int a0, input int a1, input int a2, input int a3);
    vec_t v;
    v = '0;
    v[0*W +: W] = W'(a0);
    v[1*W +: W] = W'(a1);
    v[2*W +: W] = W'(a2);
    v[3*W +: W] = W'(a3);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full window from IDLE; flush_at>=0 aborts at that time step.
  task automatic run_window(input vec_t v, input int flush_at, input bit noise,
                            input bit chain, input vec_t nxt, input bit flush_on_accept,
                            input string tag);
    logic [CW+2:0] obs_ctl, exp_ctl;
    bus.in_valid = 1'b1;
    bus.in_vals  = v;
    bus.flush    = flush_on_accept;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s accept_ready actual=%b required=1", tag, bus.in_ready);
    end
    tick();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    for (int k = 0; k < L; k++) begin
      checks++;
      if (bus.should_spike_out_l !== model_spikes(v, k)) begin
        failures++;
        $display("FAIL %s spikes k=%0d actual=%b required=%b", tag, k,
                 bus.should_spike_out_l, model_spikes(v, k));
      end
      obs_ctl = {bus.in_ready, bus.gamma_start, bus.gamma_done, bus.gamma_cnt};
      exp_ctl = {1'b0, (k == 0), (k == L - 1), CW'(k)};
      checks++;
      if (obs_ctl !== exp_ctl) begin
        failures++;
        $display("FAIL %s ctl{ready,start,done,cnt} k=%0d actual=%b required=%b",
                 tag, k, obs_ctl, exp_ctl);
      end
      if (noise) begin
        bus.in_vals  = vec_t'($urandom);
        bus.in_valid = 1'($urandom_range(0, 1));
      end
      if (k == flush_at) bus.flush = 1'b1;
      tick();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      if (k == flush_at) begin
        obs_ctl = {bus.in_ready, bus.gamma_start, bus.gamma_done, bus.gamma_cnt};
        exp_ctl = {1'b1, 1'b0, 1'b0, CW'(0)};
        checks++;
        if (obs_ctl !== exp_ctl || bus.should_spike_out_l !== '1) begin
          failures++;
          $display("FAIL %s after_flush ctl=%b spikes=%b required ctl=%b spikes=1111",
                   tag, obs_ctl, bus.should_spike_out_l, exp_ctl);
        end
        return;
      end
    end
    obs_ctl = {bus.in_ready, bus.gamma_start, bus.gamma_done, bus.gamma_cnt};
    exp_ctl = '0;
    checks++;
    if (obs_ctl !== exp_ctl || bus.should_spike_out_l !== '1) begin
      failures++;
      $display("FAIL %s rest ctl=%b spikes=%b required ctl=%b spikes=1111",
               tag, obs_ctl, bus.should_spike_out_l, exp_ctl);
    end
    if (chain) begin
      bus.in_valid = 1'b1;
      bus.in_vals  = nxt;
    end else if (noise) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_vals  = vec_t'($urandom);
    end
    tick();
    if (!chain) bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.gamma_cnt !== CW'(0) || bus.should_spike_out_l !== '1) begin
      failures++;
      $display("FAIL %s idle_after_rest ready=%b cnt=%0d spikes=%b required ready=1 cnt=0 spikes=1111",
               tag, bus.in_ready, bus.gamma_cnt, bus.should_spike_out_l);
    end
  endtask

  task automatic test_reset();
    vec_t v;
    rst_l        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_vals  = '0;
    bus.flush    = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.should_spike_out_l !== '1 || bus.gamma_start !== 1'b0 ||
        bus.gamma_done !== 1'b0 || bus.gamma_cnt !== CW'(0)) begin
      failures++;
      $display("FAIL reset_values ready=%b spikes=%b start=%b done=%b cnt=%0d required 1/1111/0/0/0",
               bus.in_ready, bus.should_spike_out_l, bus.gamma_start, bus.gamma_done, bus.gamma_cnt);
    end
    rst_l = 1'b1;
    tick();
    // Reset asserted mid-window while lines are low.
    v = pack4(0, 3, 7, 9);
    bus.in_valid = 1'b1;
    bus.in_vals  = v;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (bus.should_spike_out_l !== model_spikes(v, 3)) begin
      failures++;
      $display("FAIL reset_pre_k3 spikes actual=%b required=%b",
               bus.should_spike_out_l, model_spikes(v, 3));
    end
    #2 rst_l = 1'b0;
    #1;
    checks++;
    if (bus.should_spike_out_l !== '1 || bus.in_ready !== 1'b1 || bus.gamma_cnt !== CW'(0) ||
        bus.gamma_start !== 1'b0) begin
      failures++;
      $display("FAIL reset_async ready=%b spikes=%b cnt=%0d start=%b required 1/1111/0/0",
               bus.in_ready, bus.should_spike_out_l, bus.gamma_cnt, bus.gamma_start);
    end
    @(posedge clk);
    #1 rst_l = 1'b1;
    tick();
    checks++;
    if (bus.in_ready !== 1'b1 || bus.should_spike_out_l !== '1) begin
      failures++;
      $display("FAIL reset_release ready=%b spikes=%b required 1/1111",
               bus.in_ready, bus.should_spike_out_l);
    end
  endtask

  task automatic test_directed();
    run_window(pack4(0, 3, 7, 9), -1, 1'b0, 1'b0, '0, 1'b0, "directed");
  endtask

  task automatic test_extremes();
    run_window(pack4(0, 0, 0, 0), -1, 1'b0, 1'b0, '0, 1'b0, "all_zero");
    run_window(pack4(15, 15, 15, 15), -1, 1'b0, 1'b0, '0, 1'b0, "all_max");
    run_window(pack4(7, 8, 1, 6), -1, 1'b0, 1'b0, '0, 1'b0, "edge_7_8");
  endtask

  task automatic test_input_noise();
    run_window(pack4(2, 5, 0, 12), -1, 1'b1, 1'b0, '0, 1'b0, "noise_run");
  endtask

  task automatic test_flush();
    run_window(pack4(1, 4, 6, 2), 4, 1'b0, 1'b0, '0, 1'b0, "flush_k4");
    run_window(pack4(3, 0, 5, 7), -1, 1'b0, 1'b0, '0, 1'b0, "after_flush");
    run_window(pack4(0, 0, 8, 1), 0, 1'b0, 1'b0, '0, 1'b0, "flush_k0");
    run_window(pack4(4, 2, 6, 1), -1, 1'b0, 1'b0, '0, 1'b1, "flush_idle_accept");
  endtask

  task automatic test_back_to_back();
    vec_t a, b;
    a = pack4(6, 1, 3, 10);
    b = pack4(2, 7, 0, 4);
    run_window(a, -1, 1'b0, 1'b1, b, 1'b0, "b2b_first");
    run_window(b, -1, 1'b0, 1'b0, '0, 1'b0, "b2b_second");
  endtask

  task automatic test_random();
    for (int n = 0; n < 30; n++) begin
      vec_t v;
      int   fa;
      v  = pack4($urandom_range(0, 15), $urandom_range(0, 9),
                 $urandom_range(0, 7), $urandom_range(0, 15));
      fa = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, L - 1)) : -1;
      run_window(v, fa, 1'($urandom_range(0, 1)), 1'b0, '0, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_extremes();
    test_input_noise();
    test_flush();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
